// File: rtl/dynamic_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dynamic_add_ctrl
// Purpose  : Handshaked sequencer for a combinational ripple-carry adder that
//            waits only as many cycles as the operands' carry chain needs.
//            Optional statistics outputs enabled by DYNAMIC_ADD_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dynamic_add_ctrl #(
    parameter int  N    = 16,
    parameter int  BPC  = 4,
    localparam int WMAX = (N + BPC) / BPC,
    localparam int CW   = $clog2(WMAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_a,
    input  logic [N-1:0]  in_b,
    input  logic          in_cin,
    output logic [N-1:0]  rca_a,
    output logic [N-1:0]  rca_b,
    output logic          rca_cin,
    input  logic [N-1:0]  rca_s,
    input  logic          rca_cout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N:0]    out_sum,
    output logic [CW-1:0] out_cycles
`ifdef DYNAMIC_ADD_STATS_EN
    ,
    output logic [31:0]   stat_ops,
    output logic [31:0]   stat_wait
`endif
);

    localparam int LW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;

    logic [N-1:0]  w_diff;
    logic [LW-1:0] w_run;
    logic [LW-1:0] w_best;
    logic [CW-1:0] w_wait;
    logic          w_out_fire;

    // Longest run of propagate bits bounds how far a carry must ripple.
    always_comb begin
        w_diff = rca_a ^ rca_b;
        w_run  = '0;
        w_best = '0;
        for (int i = 0; i < N; i++) begin
            if (w_diff[i]) begin
                w_run = w_run + LW'(1);
            end else begin
                w_run = '0;
            end
            if (w_run > w_best) begin
                w_best = w_run;
            end
        end
        w_wait = CW'((32'(w_best) + BPC) / BPC);
    end

    assign w_out_fire = (r_state == S_DONE) && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            rca_a      <= '0;
            rca_b      <= '0;
            rca_cin    <= 1'b0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_sum    <= '0;
            out_cycles <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        rca_a    <= in_a;
                        rca_b    <= in_b;
                        rca_cin  <= in_cin;
                        in_ready <= 1'b0;
                        r_state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_cnt   <= w_wait;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - CW'(1);
                    // Operands are unchanged since LOAD, so w_wait is still W.
                    if (r_cnt == CW'(1)) begin
                        out_sum    <= {rca_cout, rca_s};
                        out_cycles <= w_wait;
                        out_valid  <= 1'b1;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (w_out_fire) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef DYNAMIC_ADD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops  <= '0;
            stat_wait <= '0;
        end else if (w_out_fire) begin
            stat_ops  <= stat_ops + 32'd1;
            stat_wait <= stat_wait + 32'(out_cycles);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dynamic_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dynamic_add_ctrl
// Purpose  : Self-checking bench for dynamic_add_ctrl with a ripple-carry
//            adder model that settles BPC bit positions per clock.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dynamic_add_ctrl;

    localparam int N      = 16;
    localparam int BPC    = 4;
    localparam int CW     = $clog2((N + BPC) / BPC + 1);
    localparam int N_RAND = 5000;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_a;
    logic [N-1:0]  in_b;
    logic          in_cin;
    logic [N-1:0]  rca_a;
    logic [N-1:0]  rca_b;
    logic          rca_cin;
    logic [N-1:0]  rca_s;
    logic          rca_cout;
    logic          out_valid;
    logic          out_ready;
    logic [N:0]    out_sum;
    logic [CW-1:0] out_cycles;
`ifdef DYNAMIC_ADD_STATS_EN
    logic [31:0]   stat_ops;
    logic [31:0]   stat_wait;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    dynamic_add_ctrl #(.N(N), .BPC(BPC)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_cin     (in_cin),
        .rca_a      (rca_a),
        .rca_b      (rca_b),
        .rca_cin    (rca_cin),
        .rca_s      (rca_s),
        .rca_cout   (rca_cout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_cycles (out_cycles)
`ifdef DYNAMIC_ADD_STATS_EN
        ,
        .stat_ops   (stat_ops),
        .stat_wait  (stat_wait)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Ripple-carry adder model: carries start wrong whenever the operands
    // change and advance one bit position per step, BPC steps per clock.
    // ------------------------------------------------------------------
    logic [N:0]   m_c    = '0;
    logic [2*N:0] m_prev = '1;

    function automatic logic [N:0] true_carries(input logic [N-1:0] a, input logic [N-1:0] b,
                                                input logic ci);
        logic [N:0] s;
        s = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
        return {s[N], s[N-1:0] ^ (a ^ b)};
    endfunction

    function automatic logic [N:0] ripple(input logic [N:0] c, input logic [N-1:0] a,
                                          input logic [N-1:0] b, input logic ci);
        logic [N:0] cur;
        logic [N:0] nxt;
        cur = c;
        for (int s = 0; s < BPC; s++) begin
            nxt[0] = ci;
            for (int i = 0; i < N; i++) begin
                nxt[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & cur[i]);
            end
            cur = nxt;
        end
        return cur;
    endfunction

    always @(negedge clk) begin
        if ({rca_a, rca_b, rca_cin} != m_prev) begin
            m_prev <= {rca_a, rca_b, rca_cin};
            m_c    <= ~true_carries(rca_a, rca_b, rca_cin);
        end else begin
            m_c    <= ripple(m_c, rca_a, rca_b, rca_cin);
        end
    end

    assign rca_s    = m_c[N-1:0] ^ (rca_a ^ rca_b);
    assign rca_cout = m_c[N];

    function automatic int exp_w(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] x;
        int           l;
        x = a ^ b;
        l = 0;
        while (x != '0) begin
            x = x & (x >> 1);
            l++;
        end
        return (l + 1 + BPC - 1) / BPC;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Latency counts clock edges from the accepting edge (1) up to the edge
    // that raises out_valid.
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                         output logic [N:0] s, output int cyc, output int lat);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("out_valid_rise", 32'(out_valid), 32'd1);
        s        = out_sum;
        cyc      = int'(out_cycles);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_cleared", 32'(out_valid), 32'd0);
        check("in_ready_back", 32'(in_ready), 32'd1);
    endtask

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
        logic [N:0]   sum;
        int           cyc;
        int           lat;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [N:0]   s;
        int           cyc;
        int           lat;
        int           w;
        logic [31:0]  wait_sum;
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic         rc;

        vecs[0] = '{16'h0000, 16'h0000, 1'b0, 17'h00000, 1, 3};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 17'h10000, 5, 7};
        vecs[2] = '{16'h00FF, 16'h0001, 1'b0, 17'h00100, 2, 4};
        vecs[3] = '{16'h5555, 16'hAAAA, 1'b0, 17'h0FFFF, 5, 7};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, 1, 3};
        vecs[5] = '{16'h0007, 16'h0000, 1'b0, 17'h00007, 1, 3};
        vecs[6] = '{16'h000F, 16'h0000, 1'b0, 17'h0000F, 2, 4};
        vecs[7] = '{16'h7FFF, 16'h0001, 1'b0, 17'h08000, 4, 6};
        vecs[8] = '{16'h07FF, 16'h0800, 1'b1, 17'h01000, 4, 6};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_cycles", 32'(out_cycles), 32'd0);
        check("rst_rca_a", 32'(rca_a), 32'd0);
        check("rst_rca_cin", 32'(rca_cin), 32'd0);

        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, s, cyc, lat);
            check($sformatf("vec%0d_sum", i), 32'(s), 32'(vecs[i].sum));
            check($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].cyc));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // Result held in DONE while the consumer stalls and new operands wait.
        in_valid = 1'b1;
        in_a     = 16'h00FF;
        in_b     = 16'h0001;
        in_cin   = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("hold_valid_rise", 32'(out_valid), 32'd1);
        in_valid = 1'b1;
        in_a     = 16'h1234;
        in_b     = 16'h4321;
        in_cin   = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_out_sum", 32'(out_sum), 32'h00100);
            check("hold_out_cycles", 32'(out_cycles), 32'd2);
            check("hold_rca_a", 32'(rca_a), 32'h00FF);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("hold_release_valid", 32'(out_valid), 32'd0);
        check("hold_release_ready", 32'(in_ready), 32'd1);
        check("hold_release_rca_a", 32'(rca_a), 32'h00FF);
        @(posedge clk);
        #1;
        check("hold_idle_rca_b", 32'(rca_b), 32'h0001);
        check("hold_idle_ready", 32'(in_ready), 32'd1);

        // Reset in the middle of WAIT for the longest-chain case.
        in_valid = 1'b1;
        in_a     = 16'hFFFF;
        in_b     = 16'h0000;
        in_cin   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("wait_in_ready", 32'(in_ready), 32'd0);
        check("wait_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_sum", 32'(out_sum), 32'd0);
        check("midrst_rca_a", 32'(rca_a), 32'd0);
        check("midrst_rca_cin", 32'(rca_cin), 32'd0);
`ifdef DYNAMIC_ADD_STATS_EN
        check("midrst_stat_ops", stat_ops, 32'd0);
        check("midrst_stat_wait", stat_wait, 32'd0);
`endif

        wait_sum = '0;
        for (int i = 0; i < N_RAND; i++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            rc = 1'($urandom);
            // Bias some operands toward long propagate chains.
            if ((i % 4) == 0) begin
                rb = ~ra ^ N'(1 << $urandom_range(0, N - 1));
            end
            w  = exp_w(ra, rb);
            wait_sum = wait_sum + 32'(w);
            do_op(ra, rb, rc, s, cyc, lat);
            check("rand_sum", 32'(s), 32'({1'b0, ra} + {1'b0, rb} + {{N{1'b0}}, rc}));
            check("rand_cycles", 32'(cyc), 32'(w));
            check("rand_latency", 32'(lat), 32'(w + 2));
        end
`ifdef DYNAMIC_ADD_STATS_EN
        check("stat_ops", stat_ops, 32'(N_RAND));
        check("stat_wait", stat_wait, wait_sum);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
